// File: rtl/pipeline_sink_fifo.sv
// pipeline_sink_fifo
// Collects words leaving the last stage of the byte pipeline. Each word goes
// into a small circular FIFO, and the FIFO hands it to a consumer with
// first-word fall-through.
// The pipeline cannot stall, so this block never pushes back upstream.
// A word that arrives while the FIFO is full (and nothing pops that cycle) is
// dropped. The loss is recorded in a sticky overflow flag.
// Optional feature, enabled by defining PIPE_SINK_CHECKSUM_EN: a running XOR
// of every accepted word, presented on the checksum port.
//
// Handshake: a word moves to the consumer on a rising edge where
// out_valid && out_ready. out_valid rises when the FIFO is non-empty and does
// not depend on out_ready. While out_valid is high and out_ready is low,
// out_data holds its value. out_ready is ignored while out_valid is low.
module pipeline_sink_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [AW:0]       count,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   input  logic              ovf_clr
`ifdef PIPE_SINK_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              push, pop, drop;

   // Status is decoded only from the registered count, so it never glitches
   // because of input activity.
   assign full      = (count_q == DEPTH_C);
   assign empty     = (count_q == '0);
   assign out_valid = !empty;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

   // Handshake decode. When full, a word can still enter if the head leaves
   // in the same cycle.
   assign pop  = out_valid && out_ready;
   assign push = in_valid && (!full || pop);
   assign drop = in_valid && !push;

   // Next-state logic for the pointers, the occupancy count and the sticky
   // overflow flag. A new drop wins over a clear in the same cycle.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (drop)         overflow_d = 1'b1;
      else if (ovf_clr) overflow_d = 1'b0;
   end

   // Control state. A low rst clears it at once, without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage array. It has no reset: any stale entry is hidden because
   // out_data is forced to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

`ifdef PIPE_SINK_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_q, checksum_d;

   assign checksum_d = push ? (checksum_q ^ in_data) : checksum_q;
   assign checksum   = checksum_q;

   // Running XOR of accepted words. Dropped words are excluded, and ovf_clr
   // has no effect here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) checksum_q <= '0;
      else      checksum_q <= checksum_d;
   end
`endif

endmodule

// File: doc/pipeline_sink_fifo.md
Name: pipeline_sink_fifo

Overview:
- Downstream collector for the three-stage byte pipeline.
- Captures each valid word leaving the last pipeline stage into a small circular FIFO and hands it to a consumer over a valid/ready handshake.
- The pipeline has no stall path, so this block never backpressures upstream. When full, it drops the incoming word and records the loss in a sticky overflow flag.

Parameters:
- DATA_W, 8: width of data words; matches the pipeline stage width.
- DEPTH, 4: number of FIFO entries; power of two, minimum 2.
- AW, $clog2(DEPTH): pointer width; derived, do not override.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset. Low clears all state immediately.
- in_valid  input  1  in_data carries a word from the last pipeline stage this cycle.
- in_data  input  DATA_W  word from the last pipeline stage.
- out_valid  output  1  FIFO is non-empty; out_data is valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  DATA_W  head-of-FIFO word (first-word fall-through).
- count  output  AW+1  number of occupied entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; a word was dropped because the FIFO was full.
- ovf_clr  input  1  synchronous clear of overflow.
- checksum  output  DATA_W  running XOR of accepted words; present only with the optional feature.

Behaviour:
- Reset (rst low, asynchronous):
  - wr_ptr = rd_ptr = 0, count = 0.
  - empty = 1, full = 0, out_valid = 0, overflow = 0.
  - out_data = 0, checksum = 0.
  - Memory contents are don't-care.
- Push: push = in_valid && (!full || pop). The word is written at wr_ptr and wr_ptr increments on the edge.
- Pop: pop = out_valid && out_ready. rd_ptr increments on the edge.
- Pointers wrap modulo DEPTH, from DEPTH-1 to 0.
- count update per edge:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
- Latency: a word pushed at edge N appears on out_data with out_valid = 1 from just after edge N. There is no same-cycle bypass when empty.
- First-word fall-through: out_data = mem[rd_ptr] while out_valid = 1, and is 0 while empty.
- out_data must be stable while out_valid = 1 and out_ready = 0.
- Full with in_valid and no pop:
  - the word is dropped;
  - overflow is set at that edge;
  - the FIFO contents are unchanged.
- Full with in_valid and pop in the same cycle: the word is accepted, count stays DEPTH, and overflow is not set.
- Empty with out_ready: no effect; out_ready is ignored while out_valid = 0.
- Overflow flag:
  - It stays set until ovf_clr = 1 at an edge.
  - If ovf_clr and a new drop occur in the same cycle, overflow stays 1 (the set wins).
- full, empty and out_valid are decoded from count; they must be glitch-free, registered-equivalent values.
- Reset asserted mid-stream discards all queued words. The first push after rst rises lands in entry 0.
- ovf_clr has no effect on the data path.

Optional Feature:
- Macro: PIPE_SINK_CHECKSUM_EN.
- When defined:
  - The checksum port exists.
  - On every accepted push, checksum <= checksum ^ in_data.
  - Dropped words are excluded.
  - Reset clears checksum to 0.
  - ovf_clr does not affect checksum.
- When undefined: the checksum port and its register are absent, and all other behaviour is identical.

Test Plan:
- Reset then idle (DEPTH=4) -> count=0, empty=1, out_valid=0, out_data=0, overflow=0.
- Push AA, CC, 55 on consecutive cycles with out_ready=0 -> count=3. out_data=AA holds steady. With checksum enabled, checksum = AA^CC^55 = 33.
- Push 01..05 with out_ready=0 -> count=4 and full=1. Word 05 is dropped and overflow=1. Draining then returns 01, 02, 03, 04, then empty=1.
- With the FIFO full, in_valid=1 with 77 and out_ready=1 in the same cycle -> head popped, 77 accepted, count stays 4, overflow unchanged. After 8 mixed push/pop cycles, pointers wrap and data order is preserved.
- overflow=1 then ovf_clr=1 for one cycle -> overflow=0. Repeating with a concurrent drop -> overflow stays 1.
- Hold 3 words then pull rst low between edges -> empty=1 and count=0 immediately, without waiting for a clock edge. After release, push 9C -> out_data=9C.
